// File: rtl/gcd_pkg.sv
// Shared defaults for the gcd dispatcher: datapath width, queue sizing and
// the width of the issue-credit counter.
package gcd_pkg;

    localparam int unsigned GCD_W        = 8;
    localparam int unsigned GCD_IN_DEPTH = 4;
    localparam int unsigned GCD_MAX_OUT  = 2;

    // Bits needed to hold a credit count in 0..max_out inclusive.
    function automatic int unsigned credit_width(int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

    localparam int unsigned CREDIT_W = credit_width(GCD_MAX_OUT);

endpackage

// File: rtl/gcd_dispatch_if.sv
// Bundles the operand source, hgcd engine and result consumer signals of the
// dispatcher; master is the environment side, slave is the dispatcher.
interface gcd_dispatch_if #(
    parameter int unsigned W = gcd_pkg::GCD_W
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;

    logic         ld;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rdy;
    logic [W-1:0] q;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_q;

    logic         err;
    logic [15:0]  n_done;

    modport master (
        output in_valid, in_a, in_b, rdy, q, out_ready,
        input  in_ready, ld, a, b, out_valid, out_q, err, n_done
    );

    modport slave (
        input  in_valid, in_a, in_b, rdy, q, out_ready,
        output in_ready, ld, a, b, out_valid, out_q, err, n_done
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] head
);

    localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned CW = $clog2(depth + 1);

    logic [width-1:0] mem_q [depth];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [AW-1:0] incr(logic [AW-1:0] p);
        return (p == AW'(depth - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (cnt_q == CW'(depth));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= incr(wr_q);
            if (do_pop)  rd_q <= incr(rd_q);
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data;
    end

endmodule

// File: rtl/gcd_dispatch.sv
// Credit-limited dispatcher: queues operand pairs, issues them to an in-order
// hgcd engine, and buffers the returned results for a ready/valid consumer.
module gcd_dispatch
    import gcd_pkg::*;
#(
    parameter int unsigned W        = GCD_W,
    parameter int unsigned IN_DEPTH = GCD_IN_DEPTH,
    parameter int unsigned MAX_OUT  = GCD_MAX_OUT
) (
    input logic           clk,
    input logic           reset,
    gcd_dispatch_if.slave bus
);

    localparam int unsigned CW = (MAX_OUT == GCD_MAX_OUT) ? CREDIT_W : credit_width(MAX_OUT);

    logic           op_full;
    logic           op_empty;
    logic [2*W-1:0] op_head;
    logic           op_push;

    logic           res_full;
    logic           res_empty;
    logic [W-1:0]   res_head;
    logic           res_push;

    logic           issue;
    logic           out_pop;
    logic           spurious;

    logic [CW-1:0]  credit_q;
    logic [CW-1:0]  credit_d;
    // Loads issued whose result has not yet come back on rdy.
    logic [CW-1:0]  inflight_q;
    logic [CW-1:0]  inflight_d;
    logic           ld_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           err_q;
    logic [15:0]    n_done_q;

    assign bus.in_ready  = !op_full && !reset;
    assign bus.out_valid = !res_empty && !reset;
    assign bus.out_q     = res_head;
    assign bus.ld        = ld_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.err       = err_q;
    assign bus.n_done    = n_done_q;

    assign op_push  = bus.in_valid && bus.in_ready;
    assign issue    = !op_empty && (credit_q < CW'(MAX_OUT));
    assign out_pop  = bus.out_valid && bus.out_ready;
    assign spurious = bus.rdy && (inflight_q == '0);
    assign res_push = bus.rdy && (inflight_q != '0) && !res_full;

    sync_fifo #(
        .width(2 * W),
        .depth(IN_DEPTH)
    ) u_op_fifo (
        .clk  (clk),
        .reset(reset),
        .push (op_push),
        .data ({bus.in_a, bus.in_b}),
        .pop  (issue),
        .full (op_full),
        .empty(op_empty),
        .head (op_head)
    );

    sync_fifo #(
        .width(W),
        .depth(MAX_OUT)
    ) u_res_fifo (
        .clk  (clk),
        .reset(reset),
        .push (res_push),
        .data (bus.q),
        .pop  (out_pop),
        .full (res_full),
        .empty(res_empty),
        .head (res_head)
    );

    always_comb begin
        credit_d   = credit_q;
        inflight_d = inflight_q;
        if (issue && !out_pop) begin
            credit_d = credit_q + CW'(1);
        end else if (!issue && out_pop) begin
            credit_d = credit_q - CW'(1);
        end
        if (issue && !res_push) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!issue && res_push) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q   <= '0;
            inflight_q <= '0;
            ld_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            err_q      <= 1'b0;
            n_done_q   <= '0;
        end else begin
            credit_q   <= credit_d;
            inflight_q <= inflight_d;
            ld_q       <= issue;
            if (issue) {a_q, b_q} <= op_head;
            if (spurious) err_q <= 1'b1;
            if (out_pop) n_done_q <= n_done_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_gcd_dispatch.sv
// Directed and table-driven bench for gcd_dispatch with a fixed-latency
// in-order hgcd model and a reference gcd.
module tb_gcd_dispatch;

    localparam int unsigned W   = 8;
    localparam int unsigned LAT = 5;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_q;
    } vec_t;

    typedef struct {
        int unsigned due;
        logic [7:0]  q;
    } mdl_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    gcd_dispatch_if #(.W(W)) bus ();

    gcd_dispatch #(
        .W       (W),
        .IN_DEPTH(4),
        .MAX_OUT (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    pair_t       src_q[$];
    logic [7:0]  exp_res[$];
    logic [7:0]  got_res[$];
    mdl_t        mdl_q[$];
    vec_t        vecs[8];

    bit          model_en;
    bit          ir_low_seen;
    int unsigned ld_count;
    int unsigned ov_count;
    int unsigned push_count;
    int unsigned last_ld_cyc;
    int unsigned last_push_cyc;
    logic [7:0]  last_a;
    logic [7:0]  last_b;

    function automatic logic [7:0] gcd_ref(logic [7:0] x, logic [7:0] y);
        logic [7:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Handshakes are sampled mid-cycle, the clock edge passes, then outputs
    // are observed and the hgcd model and source are driven for the new cycle.
    task automatic step();
        bit pushed;
        mdl_t m;
        @(negedge clk);
        pushed = bus.in_valid && bus.in_ready;
        if (pushed) begin
            src_q.delete(0);
            push_count++;
        end
        if (bus.out_valid && bus.out_ready) got_res.push_back(bus.out_q);
        @(posedge clk);
        #1;
        cyc++;
        if (pushed) last_push_cyc = cyc;
        if (bus.ld) begin
            ld_count++;
            last_ld_cyc = cyc;
            last_a      = bus.a;
            last_b      = bus.b;
            if (model_en) begin
                m.due = cyc + LAT;
                m.q   = gcd_ref(bus.a, bus.b);
                mdl_q.push_back(m);
            end
        end
        if (model_en) begin
            if (mdl_q.size() > 0 && mdl_q[0].due == cyc) begin
                bus.rdy = 1'b1;
                bus.q   = mdl_q[0].q;
                mdl_q.delete(0);
            end else begin
                bus.rdy = 1'b0;
            end
        end
        if (bus.out_valid) ov_count++;
        if (!reset && !bus.in_ready) ir_low_seen = 1'b1;
        bus.in_valid = (src_q.size() > 0);
        if (src_q.size() > 0) begin
            bus.in_a = src_q[0].a;
            bus.in_b = src_q[0].b;
        end
    endtask

    task automatic add_pair(logic [7:0] a, logic [7:0] b);
        pair_t p;
        p.a = a;
        p.b = b;
        src_q.push_back(p);
        exp_res.push_back(gcd_ref(a, b));
    endtask

    // flush=0 keeps the hgcd model's pending results so they arrive after reset.
    task automatic do_reset(bit flush);
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        src_q.delete();
        if (flush) begin
            mdl_q.delete();
            bus.rdy = 1'b0;
        end
        step();
        check("rst_in_ready_low", 32'(bus.in_ready), 0);
        check("rst_out_valid_low", 32'(bus.out_valid), 0);
        step();
        reset = 1'b0;
        check("rst_ld", 32'(bus.ld), 0);
        check("rst_a", 32'(bus.a), 0);
        check("rst_b", 32'(bus.b), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_n_done", 32'(bus.n_done), 0);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        got_res.delete();
        exp_res.delete();
        ld_count    = 0;
        ov_count    = 0;
        push_count  = 0;
        ir_low_seen = 1'b0;
    endtask

    task automatic check_results(string tag, int unsigned n);
        int unsigned act;
        check({tag, "_count"}, got_res.size(), n);
        for (int i = 0; i < int'(n); i++) begin
            act = (i < got_res.size()) ? 32'(got_res[i]) : 999;
            check($sformatf("%s_res%0d", tag, i), act, 32'(exp_res[i]));
        end
    endtask

    initial begin
        int unsigned e_cyc;
        int unsigned base_nd;

        vecs[0] = '{a: 8'd12,  b: 8'd18,  exp_q: 8'd6};
        vecs[1] = '{a: 8'd48,  b: 8'd36,  exp_q: 8'd12};
        vecs[2] = '{a: 8'd17,  b: 8'd5,   exp_q: 8'd1};
        vecs[3] = '{a: 8'd0,   b: 8'd9,   exp_q: 8'd9};
        vecs[4] = '{a: 8'd255, b: 8'd85,  exp_q: 8'd85};
        vecs[5] = '{a: 8'd100, b: 8'd75,  exp_q: 8'd25};
        vecs[6] = '{a: 8'd7,   b: 8'd7,   exp_q: 8'd7};
        vecs[7] = '{a: 8'd240, b: 8'd1,   exp_q: 8'd1};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.rdy       = 1'b0;
        bus.q         = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        model_en      = 1'b1;
        do_reset(1'b1);

        // Single pairs through the whole path, consumer always ready.
        for (int i = 0; i < 8; i++) begin
            pair_t p;
            bus.out_ready = 1'b1;
            base_nd  = 32'(bus.n_done);
            ld_count = 0;
            ov_count = 0;
            got_res.delete();
            p.a = vecs[i].a;
            p.b = vecs[i].b;
            src_q.push_back(p);
            repeat (20) step();
            check($sformatf("v%0d_ld_pulses", i), ld_count, 1);
            check($sformatf("v%0d_ld_latency", i), last_ld_cyc - last_push_cyc, 1);
            check($sformatf("v%0d_a", i), 32'(last_a), 32'(vecs[i].a));
            check($sformatf("v%0d_b", i), 32'(last_b), 32'(vecs[i].b));
            check($sformatf("v%0d_nres", i), got_res.size(), 1);
            check($sformatf("v%0d_out_q", i), (got_res.size() > 0) ? 32'(got_res[0]) : 999,
                  32'(vecs[i].exp_q));
            check($sformatf("v%0d_valid_cycles", i), ov_count, 1);
            check($sformatf("v%0d_n_done", i), 32'(bus.n_done), base_nd + 1);
        end
        check("table_err", 32'(bus.err), 0);

        // Credit limit: four pairs, consumer stalled.
        do_reset(1'b1);
        add_pair(8'd30, 8'd45);
        add_pair(8'd21, 8'd14);
        add_pair(8'd64, 8'd48);
        add_pair(8'd9,  8'd27);
        repeat (30) step();
        check("credit_ld_pulses", ld_count, 2);
        check("credit_in_ready_stayed", 32'(ir_low_seen), 0);
        check("credit_pushed", push_count, 4);
        check("credit_out_valid", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        repeat (40) step();
        check("credit_ld_total", ld_count, 4);
        check_results("credit", 4);
        check("credit_n_done", 32'(bus.n_done), 4);
        check("credit_err", 32'(bus.err), 0);

        // Backpressure: no hgcd results ever come back.
        do_reset(1'b1);
        model_en = 1'b0;
        for (int i = 0; i < 7; i++) add_pair(8'(i + 1), 8'(i + 2));
        repeat (20) step();
        check("bp_accepted", push_count, 6);
        check("bp_in_ready", 32'(bus.in_ready), 0);
        check("bp_ld_pulses", ld_count, 2);
        check("bp_left_in_src", src_q.size(), 1);

        // Reset drops the queued pairs.
        do_reset(1'b1);
        repeat (10) step();
        check("bp_flush_ld", ld_count, 0);
        check("bp_flush_out_valid", 32'(bus.out_valid), 0);

        // Reset while a load is in flight: its late result is spurious.
        model_en = 1'b1;
        do_reset(1'b1);
        add_pair(8'd12, 8'd18);
        for (int i = 0; i < 10 && ld_count == 0; i++) step();
        check("mid_ld_seen", ld_count, 1);
        do_reset(1'b0);
        repeat (10) step();
        check("mid_err", 32'(bus.err), 1);
        check("mid_out_valid", 32'(bus.out_valid), 0);
        check("mid_ld", ld_count, 0);

        // Spurious rdy straight after reset.
        model_en = 1'b0;
        do_reset(1'b1);
        bus.rdy = 1'b1;
        bus.q   = 8'd7;
        step();
        bus.rdy = 1'b0;
        step();
        check("spur_err", 32'(bus.err), 1);
        check("spur_out_valid", 32'(bus.out_valid), 0);
        repeat (10) step();
        check("spur_err_sticky", 32'(bus.err), 1);
        check("spur_never_valid", ov_count, 0);
        do_reset(1'b1);
        check("spur_err_cleared", 32'(bus.err), 0);

        // Pop with credit at the limit frees exactly one issue slot.
        model_en = 1'b1;
        do_reset(1'b1);
        add_pair(8'd12, 8'd18);
        add_pair(8'd35, 8'd49);
        add_pair(8'd81, 8'd27);
        add_pair(8'd44, 8'd121);
        repeat (20) step();
        check("sim_ld_before", ld_count, 2);
        check("sim_out_valid", 32'(bus.out_valid), 1);
        check("sim_src_drained", src_q.size(), 0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        e_cyc = cyc;
        repeat (15) step();
        check("sim_ld_after", ld_count, 3);
        check("sim_ld_cycle", last_ld_cyc, e_cyc + 1);
        check("sim_first_res", (got_res.size() > 0) ? 32'(got_res[0]) : 999, 6);
        bus.out_ready = 1'b1;
        repeat (40) step();
        check("sim_ld_total", ld_count, 4);
        check_results("sim", 4);
        check("sim_n_done", 32'(bus.n_done), 4);

        // Soak with random operands and a random consumer.
        do_reset(1'b1);
        for (int i = 0; i < 100; i++) add_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 5000 && got_res.size() < 100; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        bus.out_ready = 1'b0;
        check_results("soak", 100);
        check("soak_n_done", 32'(bus.n_done), 100);
        check("soak_err", 32'(bus.err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcd_dispatch.md
GCD_DISPATCH -- requirements
Module: gcd_dispatch

Interface
REQ-001 Parameter W, default 8: operand and result width in bits.
REQ-002 Parameter IN_DEPTH, default 4: operand FIFO depth, a power of two.
REQ-003 Parameter MAX_OUT, default 2: maximum hgcd operations in flight plus unconsumed results.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: source offers an operand pair.
REQ-007 Port in_ready, output, 1: dispatcher accepts the pair this cycle.
REQ-008 Port in_a / in_b, input, W each: operand pair.
REQ-009 Port ld, output, 1: one-cycle load strobe to hgcd.
REQ-010 Port a / b, output, W each: operands to hgcd, valid while ld=1.
REQ-011 Port rdy, input, 1: hgcd result strobe, one cycle per result.
REQ-012 Port q, input, W: hgcd result, valid while rdy=1.
REQ-013 Port out_valid, output, 1: result available to the consumer.
REQ-014 Port out_ready, input, 1: consumer takes the result.
REQ-015 Port out_q, output, W: head result.
REQ-016 Port err, output, 1: sticky protocol-violation flag.
REQ-017 Port n_done, output, 16: count of results delivered to the consumer.

Function
REQ-018 in_ready SHALL equal (operand FIFO not full) AND (NOT reset); a push occurs on a rising edge where in_valid and in_ready are both 1.
REQ-019 The credit counter SHALL count issued loads whose results have not yet been popped at the output, within the range 0..MAX_OUT.
REQ-020 On each edge where the operand FIFO is non-empty and credit < MAX_OUT, the block SHALL pop the FIFO head, register it onto a/b, drive ld=1 for the next cycle, and increment credit.
REQ-021 Otherwise ld SHALL be 0 in the next cycle, and a/b SHALL hold their last values.
REQ-022 ld SHALL never be high on two consecutive cycles unless the FIFO held at least two pairs and credit allowed both issues; each ld corresponds to exactly one popped pair, in FIFO order.
REQ-023 Minimum latency SHALL be: pair pushed at edge N, ld high in the cycle after edge N+1; there is no bypass path.
REQ-024 When rdy=1, q SHALL be written into a result FIFO of depth MAX_OUT.
REQ-025 out_valid SHALL equal result FIFO non-empty, and out_q SHALL equal the result FIFO head.
REQ-026 A pop occurs when out_valid and out_ready are both 1; it SHALL decrement credit and increment n_done, which wraps modulo 2^16.
REQ-027 When an issue and a pop occur on the same edge, credit SHALL be unchanged.
REQ-028 When a push and an issue occur on the same edge with the FIFO full, both SHALL complete.
REQ-029 rdy arriving with zero in-flight operations (credit minus result-FIFO occupancy equal to 0) SHALL set err, and q SHALL be discarded.
REQ-030 err SHALL clear only on reset.
REQ-031 Results SHALL be delivered in issue order; hgcd is required to be in-order.

Reset
REQ-032 While reset=1 at an edge, the block SHALL clear: both FIFOs empty, credit=0, ld=0, a=b=0, err=0, n_done=0.
REQ-033 out_valid SHALL be 0 and in_ready SHALL be 0 while reset=1.
REQ-034 Reset mid-operation SHALL discard queued pairs and buffered results; rdy pulses arriving after reset SHALL set err.

Structure
REQ-035 Package gcd_pkg SHALL hold the W, IN_DEPTH and MAX_OUT defaults and the credit-counter width constant.
REQ-036 A single sub-module sync_fifo (parameters width and depth; ports push, pop, full, empty, head) SHALL be instantiated twice: operands at width 2W, depth IN_DEPTH; results at width W, depth MAX_OUT.

Verification
REQ-037 The bench SHALL cover a single pair: push (12,18) with out_ready=1 and hgcd model latency 5 -> ld pulses once with a=12, b=18; out_q=6, out_valid for 1 cycle, n_done=1.
REQ-038 The bench SHALL cover credit limit: push 4 pairs back-to-back with out_ready=0 -> exactly 2 ld pulses; in_ready stays 1; no further ld until out_ready=1.
REQ-039 The bench SHALL cover backpressure: push 6 pairs with no rdy -> in_ready drops after 6 accepted pairs (4 queued + 2 issued).
REQ-040 The bench SHALL cover the simultaneous case: with credit=2, a result pop and a queued pair on the same edge -> ld fires on the next cycle and credit stays 2.
REQ-041 The bench SHALL cover spurious rdy: rdy=1 with q=7 after reset -> err=1, out_valid stays 0, err persists until reset.
REQ-042 The bench SHALL cover a soak: 100 random 8-bit pairs with random out_ready -> all 100 results match a reference gcd in order, n_done=100, err=0.
